vc_mem_read_streamer: RTL

//  Upstream requester for the vcMem single-port memories. Accepts one command (base, stride, count),

---
 rtl/vc_mem_read_streamer_pkg.sv | 14 +
 rtl/vc_mem_read_streamer_fifo.sv | 69 ++++++
 rtl/vc_mem_read_streamer.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/vc_mem_read_streamer_pkg.sv
// Shared definitions for the vcMem read streamer: memreq rw encoding and FSM state encoding.
// The rw encoding matches the one used by other vcMemories users.
package vc_mem_read_streamer_pkg;

    localparam logic VC_MEM_RW_READ  = 1'b0;
    localparam logic VC_MEM_RW_WRITE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/vc_mem_read_streamer_fifo.sv
// Response buffer for the read streamer: a circular FIFO with registered head/tail/count.
// Writes into a full buffer are dropped; the credit logic upstream keeps that from happening.
module vc_stream_fifo #(
    parameter int DATA_SZ     = 32,
    parameter int BUF_ENTRIES = 4,
    parameter int BUF_IDX_SZ  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enq_val,
    input  logic [DATA_SZ-1:0]    enq_bits,
    output logic                  deq_val,
    input  logic                  deq_rdy,
    output logic [DATA_SZ-1:0]    deq_bits,
    output logic [BUF_IDX_SZ:0]   occupancy
);

    localparam logic [BUF_IDX_SZ:0] FULL_CNT = (BUF_IDX_SZ+1)'(BUF_ENTRIES);

    logic [DATA_SZ-1:0]    mem_q [BUF_ENTRIES];
    logic [DATA_SZ-1:0]    mem_d [BUF_ENTRIES];
    logic [BUF_IDX_SZ-1:0] head_q, head_d;
    logic [BUF_IDX_SZ-1:0] tail_q, tail_d;
    logic [BUF_IDX_SZ:0]   count_q, count_d;
    logic                  push;
    logic                  pop;

    assign deq_val   = (count_q != '0);
    assign deq_bits  = mem_q[head_q];
    assign occupancy = count_q;
    assign push      = enq_val && (count_q != FULL_CNT);
    assign pop       = deq_val && deq_rdy;

    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push) begin
            mem_d[tail_q] = enq_bits;
            tail_d        = tail_q + BUF_IDX_SZ'(1);
        end
        if (pop) begin
            head_d = head_q + BUF_IDX_SZ'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (BUF_IDX_SZ+1)'(1);
            2'b01:   count_d = count_q - (BUF_IDX_SZ+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BUF_ENTRIES; i++) begin
                mem_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/vc_mem_read_streamer.sv
// Strided read requester for vcMem single-port memories: one command in, count reads out,
// responses buffered and streamed in request order. Credits keep every response a slot.
module vc_mem_read_streamer
    import vc_mem_read_streamer_pkg::*;
#(
    parameter int ADDR_SZ     = 8,
    parameter int DATA_SZ     = 32,
    parameter int CNT_SZ      = 8,
    parameter int BUF_ENTRIES = 4,
    parameter int BUF_IDX_SZ  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_val,
    output logic               cmd_rdy,
    input  logic [ADDR_SZ-1:0] cmd_bits_base,
    input  logic [ADDR_SZ-1:0] cmd_bits_stride,
    input  logic [CNT_SZ-1:0]  cmd_bits_count,
    output logic               memreq_val,
    input  logic               memreq_rdy,
    output logic               memreq_bits_rw,
    output logic [ADDR_SZ-1:0] memreq_bits_addr,
    output logic [DATA_SZ-1:0] memreq_bits_data,
    input  logic               memresp_val,
    input  logic [DATA_SZ-1:0] memresp_bits_data,
    output logic               out_val,
    input  logic               out_rdy,
    output logic [DATA_SZ-1:0] out_bits,
    output logic               busy,
    output logic [1:0]         dbg_state
);

    localparam logic [BUF_IDX_SZ:0] BUF_ENTRIES_W = (BUF_IDX_SZ+1)'(BUF_ENTRIES);

    state_e              state_q, state_d;
    logic [ADDR_SZ-1:0]  addr_q, addr_d;
    logic [ADDR_SZ-1:0]  stride_q, stride_d;
    logic [CNT_SZ-1:0]   remaining_q, remaining_d;
    logic [BUF_IDX_SZ:0] outstanding_q, outstanding_d;
    logic [BUF_IDX_SZ:0] occupancy;
    logic [BUF_IDX_SZ:0] credits;
    logic                cmd_fire;
    logic                req_fire;
    logic                resp_ok;

    // Credits come from registered state only, so memreq_val has no path from memresp_val.
    assign credits  = BUF_ENTRIES_W - occupancy - outstanding_q;
    assign cmd_fire = cmd_val && cmd_rdy;
    assign req_fire = memreq_val && memreq_rdy;
    assign resp_ok  = memresp_val && (outstanding_q != '0);

    assign memreq_bits_rw   = VC_MEM_RW_READ;
    assign memreq_bits_addr = addr_q;
    assign memreq_bits_data = '0;
    assign dbg_state        = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_fire && (cmd_bits_count != '0)) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (req_fire && (remaining_q == CNT_SZ'(1))) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if ((outstanding_q == '0) && (occupancy == '0)) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_rdy    = (state_q == ST_IDLE);
        memreq_val = (state_q == ST_ISSUE) && (credits != '0);
        busy       = (state_q != ST_IDLE);
    end

    always_comb begin
        addr_d        = addr_q;
        stride_d      = stride_q;
        remaining_d   = remaining_q;
        outstanding_d = outstanding_q;
        if (cmd_fire) begin
            addr_d      = cmd_bits_base;
            stride_d    = cmd_bits_stride;
            remaining_d = cmd_bits_count;
        end
        if (req_fire) begin
            addr_d      = addr_q + stride_q;
            remaining_d = remaining_q - CNT_SZ'(1);
        end
        case ({req_fire, resp_ok})
            2'b10:   outstanding_d = outstanding_q + (BUF_IDX_SZ+1)'(1);
            2'b01:   outstanding_d = outstanding_q - (BUF_IDX_SZ+1)'(1);
            default: outstanding_d = outstanding_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q        <= '0;
            stride_q      <= '0;
            remaining_q   <= '0;
            outstanding_q <= '0;
        end else begin
            addr_q        <= addr_d;
            stride_q      <= stride_d;
            remaining_q   <= remaining_d;
            outstanding_q <= outstanding_d;
        end
    end

    vc_stream_fifo #(
        .DATA_SZ     (DATA_SZ),
        .BUF_ENTRIES (BUF_ENTRIES),
        .BUF_IDX_SZ  (BUF_IDX_SZ)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .enq_val   (resp_ok),
        .enq_bits  (memresp_bits_data),
        .deq_val   (out_val),
        .deq_rdy   (out_rdy),
        .deq_bits  (out_bits),
        .occupancy (occupancy)
    );

    // A response with nothing outstanding is dropped; flag it in simulation.
    resp_needs_outstanding: assert property (
        @(posedge clk) disable iff (rst) memresp_val |-> (outstanding_q != '0)
    ) else $error("vc_mem_read_streamer: memresp with no outstanding request, data dropped");

endmodule
